// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one memory request port between an instruction-fetch requester (im_*)
//   and a data requester (dm_*). The request path and the response path are
//   purely combinational. Requests reach memory in the cycle they are presented,
//   and responses reach the requester in the cycle they arrive.
//
//   Responses come back in order, one per accepted request. An in-order FIFO of
//   requester IDs (0 = fetch, 1 = data) steers each response. A request is only
//   eligible while fewer than MaxOutstanding transactions are in flight. The
//   in-flight count used for this test is the registered count.
//
//   Optional feature (compile-time macro MEM_ARB_ROUND_ROBIN_EN):
//     defined   : on contention, the requester that was not granted in the most
//                 recent completed transfer wins. Out of reset, fetch is
//                 preferred.
//     undefined : fixed priority; the data requester wins any contention.
//
// Ports
//   clk_i, rst_i                   clock, synchronous active-high reset
//   im_valid_i/im_addr_i           fetch request (read only)
//   im_ready_o                     fetch request accepted this cycle
//   im_rvalid_o/im_rdata_o         fetch response
//   dm_valid_i/dm_addr_i/dm_we_i/
//   dm_wdata_i/dm_wstrb_i          data request
//   dm_ready_o                     data request accepted this cycle
//   dm_rvalid_o/dm_rdata_o         data response (reads and writes)
//   mem_valid_o/mem_addr_o/mem_we_o/
//   mem_wdata_o/mem_wstrb_o        forwarded memory request
//   mem_ready_i                    memory accepts request
//   mem_rvalid_i/mem_rdata_i       memory response, in order
module mem_arbiter #(
  parameter int AddrWidth      = 32,
  parameter int DataWidth      = 32,
  parameter int MaxOutstanding = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   im_valid_i,
  input  logic [AddrWidth-1:0]   im_addr_i,
  output logic                   im_ready_o,
  output logic                   im_rvalid_o,
  output logic [DataWidth-1:0]   im_rdata_o,
  input  logic                   dm_valid_i,
  input  logic [AddrWidth-1:0]   dm_addr_i,
  input  logic                   dm_we_i,
  input  logic [DataWidth-1:0]   dm_wdata_i,
  input  logic [DataWidth/8-1:0] dm_wstrb_i,
  output logic                   dm_ready_o,
  output logic                   dm_rvalid_o,
  output logic [DataWidth-1:0]   dm_rdata_o,
  output logic                   mem_valid_o,
  output logic [AddrWidth-1:0]   mem_addr_o,
  output logic                   mem_we_o,
  output logic [DataWidth-1:0]   mem_wdata_o,
  output logic [DataWidth/8-1:0] mem_wstrb_o,
  input  logic                   mem_ready_i,
  input  logic                   mem_rvalid_i,
  input  logic [DataWidth-1:0]   mem_rdata_i
);

  localparam int PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int CntW = $clog2(MaxOutstanding + 1);
  localparam logic [PtrW-1:0] PtrLast = PtrW'(MaxOutstanding - 1);
  localparam logic [CntW-1:0] CntMax  = CntW'(MaxOutstanding);
  localparam logic IdFetch = 1'b0;
  localparam logic IdData  = 1'b1;

  logic [CntW-1:0] count_q, count_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic            id_fifo_q [MaxOutstanding];
  logic            lock_q, lock_d;
  logic            lock_id_q, lock_id_d;

  logic eligible;
  logic req_valid;
  logic winner;
  logic push;
  logic pop;
  logic rsp_id;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // rr_q holds the ID that wins the next contention.
  logic rr_q, rr_d;
`endif

  // Pointers wrap explicitly so a depth of 1 works as well.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrLast) ? '0 : p + PtrW'(1);
  endfunction

  // Arbitration and request forwarding.
  always_comb begin
    eligible  = !rst_i && (count_q < CntMax);
    req_valid = im_valid_i || dm_valid_i;
    winner    = dm_valid_i ? IdData : IdFetch;
    // A stalled grant stays with its owner while that owner keeps requesting.
    if (lock_q && (lock_id_q == IdData ? dm_valid_i : im_valid_i)) begin
      winner = lock_id_q;
    end else if (im_valid_i && dm_valid_i) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      winner = rr_q;
`else
      winner = IdData;
`endif
    end

    mem_valid_o = eligible && req_valid;
    mem_addr_o  = (winner == IdData) ? dm_addr_i : im_addr_i;
    mem_we_o    = (winner == IdData) && dm_we_i;
    mem_wdata_o = (winner == IdData) ? dm_wdata_i : '0;
    mem_wstrb_o = (winner == IdData) ? dm_wstrb_i : '0;

    im_ready_o  = mem_valid_o && mem_ready_i && (winner == IdFetch);
    dm_ready_o  = mem_valid_o && mem_ready_i && (winner == IdData);
  end

  // Response steering. A response with nothing outstanding is ignored.
  always_comb begin
    push        = mem_valid_o && mem_ready_i;
    pop         = !rst_i && mem_rvalid_i && (count_q != '0);
    rsp_id      = id_fifo_q[rd_ptr_q];
    im_rvalid_o = pop && (rsp_id == IdFetch);
    dm_rvalid_o = pop && (rsp_id == IdData);
    im_rdata_o  = mem_rdata_i;
    dm_rdata_o  = mem_rdata_i;
  end

  // Next-state logic.
  always_comb begin
    count_d   = count_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    lock_d    = mem_valid_o && !mem_ready_i;
    lock_id_d = winner;
    if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
`ifdef MEM_ARB_ROUND_ROBIN_EN
    rr_d = push ? ~winner : rr_q;
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      lock_q    <= 1'b0;
      lock_id_q <= IdFetch;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      rr_q      <= IdFetch;
`endif
    end else begin
      count_q   <= count_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      rr_q      <= rr_d;
`endif
    end
  end

  // ID storage carries no reset; only entries below count_q are ever read.
  always_ff @(posedge clk_i) begin
    if (push) id_fifo_q[wr_ptr_q] <= winner;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter. Stimulus pushes expected memory transfers and
// expected responses into queues; a monitor on the falling edge pops and compares
// whenever the DUT shows a transfer or a response.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        im_valid_i;
  logic [31:0] im_addr_i;
  logic        im_ready_o, im_rvalid_o;
  logic [31:0] im_rdata_o;
  logic        dm_valid_i;
  logic [31:0] dm_addr_i;
  logic        dm_we_i;
  logic [31:0] dm_wdata_i;
  logic [3:0]  dm_wstrb_i;
  logic        dm_ready_o, dm_rvalid_o;
  logic [31:0] dm_rdata_o;
  logic        mem_valid_o;
  logic [31:0] mem_addr_o;
  logic        mem_we_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_wstrb_o;
  logic        mem_ready_i, mem_rvalid_i;
  logic [31:0] mem_rdata_i;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk_i(clk), .rst_i(rst_i),
    .im_valid_i(im_valid_i), .im_addr_i(im_addr_i), .im_ready_o(im_ready_o),
    .im_rvalid_o(im_rvalid_o), .im_rdata_o(im_rdata_o),
    .dm_valid_i(dm_valid_i), .dm_addr_i(dm_addr_i), .dm_we_i(dm_we_i),
    .dm_wdata_i(dm_wdata_i), .dm_wstrb_i(dm_wstrb_i), .dm_ready_o(dm_ready_o),
    .dm_rvalid_o(dm_rvalid_o), .dm_rdata_o(dm_rdata_o),
    .mem_valid_o(mem_valid_o), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o),
    .mem_wdata_o(mem_wdata_o), .mem_wstrb_o(mem_wstrb_o), .mem_ready_i(mem_ready_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
  );

  typedef struct packed {
    logic        ir;
    logic        dr;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wd;
    logic [3:0]  ws;
  } xfer_t;

  typedef struct packed {
    logic        iv;
    logic        dv;
    logic [31:0] data;
  } rsp_t;

  xfer_t xq[$];
  rsp_t  rq[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Expected transfer: F = fetch granted, D = data granted.
  task automatic exp_f(input logic [31:0] a);
    xq.push_back(xfer_t'{ir: 1'b1, dr: 1'b0, addr: a, we: 1'b0, wd: 32'h0, ws: 4'h0});
  endtask
  task automatic exp_d(input logic [31:0] a, input logic w, input logic [31:0] d, input logic [3:0] s);
    xq.push_back(xfer_t'{ir: 1'b0, dr: 1'b1, addr: a, we: w, wd: d, ws: s});
  endtask
  task automatic exp_grant(input logic id, input logic [31:0] fa, input logic [31:0] da);
    if (id) exp_d(da, 1'b0, 32'h0, 4'h0);
    else    exp_f(fa);
  endtask
  // Drive a memory response and record which requester must receive it.
  task automatic respond(input logic id, input logic [31:0] d);
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = d;
    rq.push_back(rsp_t'{iv: ~id, dv: id, data: d});
  endtask

  // Monitor: compare every transfer and every response against the queues.
  always @(negedge clk) begin
    if (mem_valid_o && mem_ready_i) begin
      xfer_t act;
      act = xfer_t'{ir: im_ready_o, dr: dm_ready_o, addr: mem_addr_o, we: mem_we_o,
                    wd: mem_wdata_o, ws: mem_wstrb_o};
      if (xq.size() == 0) check("unexpected_xfer", 128'(act), 128'h0);
      else                check("xfer", 128'(act), 128'(xq.pop_front()));
    end
    if (im_rvalid_o || dm_rvalid_o) begin
      rsp_t act;
      act = rsp_t'{iv: im_rvalid_o, dv: dm_rvalid_o,
                   data: dm_rvalid_o ? dm_rdata_o : im_rdata_o};
      if (rq.size() == 0) check("unexpected_rsp", 128'(act), 128'h0);
      else                check("rsp", 128'(act), 128'(rq.pop_front()));
    end
  end

  task automatic idle();
    im_valid_i = 1'b0; im_addr_i = 32'h0;
    dm_valid_i = 1'b0; dm_addr_i = 32'h0; dm_we_i = 1'b0;
    dm_wdata_i = 32'h0; dm_wstrb_i = 4'h0;
    mem_ready_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  logic g [4];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
    g[0] = 1'b0; g[1] = 1'b1; g[2] = 1'b0; g[3] = 1'b1;
`else
    g[0] = 1'b1; g[1] = 1'b1; g[2] = 1'b1; g[3] = 1'b1;
`endif
    idle();
    rst_i = 1'b1;

    // Reset with a live request: nothing may be granted.
    next_cycle(); im_valid_i = 1'b1; im_addr_i = 32'h10; mem_ready_i = 1'b1; settle();
    check("rst_mem_valid", 128'(mem_valid_o), 128'h0);
    check("rst_im_ready", 128'(im_ready_o), 128'h0);
    next_cycle(); idle(); rst_i = 1'b0; settle();
    check("post_rst_outputs", 128'({mem_valid_o, im_ready_o, dm_ready_o, im_rvalid_o, dm_rvalid_o}), 128'h0);

    // Single fetch, response one cycle later.
    next_cycle(); im_valid_i = 1'b1; im_addr_i = 32'h100; mem_ready_i = 1'b1; exp_f(32'h100); settle();
    check("t1_im_ready", 128'(im_ready_o), 128'h1);
    next_cycle(); idle(); respond(1'b0, 32'hDEADBEEF); settle();
    check("t1_im_rvalid", 128'(im_rvalid_o), 128'h1);
    check("t1_dm_rvalid", 128'(dm_rvalid_o), 128'h0);
    next_cycle(); idle();

    // Fresh reset so a round-robin pointer starts at fetch.
    rst_i = 1'b1; next_cycle(); rst_i = 1'b0;

    // Continuous contention, immediate responses.
    for (int k = 0; k < 4; k++) begin
      next_cycle(); idle();
      im_valid_i = 1'b1; im_addr_i = 32'h40;
      dm_valid_i = 1'b1; dm_addr_i = 32'h80;
      mem_ready_i = 1'b1;
      exp_grant(g[k], 32'h40, 32'h80);
      if (k > 0) respond(g[k-1], 32'h1000 + 32'(k - 1));
      settle();
      check("t2_mem_valid", 128'(mem_valid_o), 128'h1);
      check("t2_dm_ready", 128'(dm_ready_o), 128'(g[k]));
    end
    // Push and pop together at count 1, then one more accept, then full.
    next_cycle(); idle(); im_valid_i = 1'b1; im_addr_i = 32'h44; mem_ready_i = 1'b1;
    exp_f(32'h44); respond(g[3], 32'h1003); settle();
    next_cycle(); idle(); im_valid_i = 1'b1; im_addr_i = 32'h48; mem_ready_i = 1'b1;
    exp_f(32'h48); settle();
    check("t2_accept_at_cnt1", 128'(im_ready_o), 128'h1);
    next_cycle(); idle(); im_valid_i = 1'b1; dm_valid_i = 1'b1; mem_ready_i = 1'b1; settle();
    check("t2_full_blocked", 128'({mem_valid_o, im_ready_o, dm_ready_o}), 128'h0);
    next_cycle(); idle(); respond(1'b0, 32'h2000);
    next_cycle(); idle(); respond(1'b0, 32'h2001);
    next_cycle(); idle();

    // Stalled data write held against a competing fetch.
    for (int k = 0; k < 4; k++) begin
      next_cycle(); idle();
      dm_valid_i = 1'b1; dm_addr_i = 32'h200; dm_we_i = 1'b1;
      dm_wdata_i = 32'hCAFEF00D; dm_wstrb_i = 4'h3;
      im_valid_i = 1'b1; im_addr_i = 32'h300;
      mem_ready_i = (k == 3);
      if (k == 3) exp_d(32'h200, 1'b1, 32'hCAFEF00D, 4'h3);
      settle();
      check("t3_addr", 128'(mem_addr_o), 128'h200);
      check("t3_dm_ready", 128'(dm_ready_o), 128'(k == 3));
    end
    next_cycle(); idle(); im_valid_i = 1'b1; im_addr_i = 32'h300; mem_ready_i = 1'b1; exp_f(32'h300);
    next_cycle(); idle(); respond(1'b1, 32'h3000); settle();
    check("t3_rsp_data_port", 128'({im_rvalid_o, dm_rvalid_o}), 128'h1);
    next_cycle(); idle(); respond(1'b0, 32'h3001);
    next_cycle(); idle();

    // Stalled fetch keeps the grant when data arrives.
    next_cycle(); idle(); im_valid_i = 1'b1; im_addr_i = 32'h500; settle();
    check("t4_addr_c1", 128'(mem_addr_o), 128'h500);
    next_cycle(); dm_valid_i = 1'b1; dm_addr_i = 32'h600; settle();
    check("t4_addr_locked", 128'(mem_addr_o), 128'h500);
    next_cycle(); mem_ready_i = 1'b1; exp_f(32'h500); settle();
    check("t4_im_ready", 128'(im_ready_o), 128'h1);
    next_cycle(); im_valid_i = 1'b0; exp_d(32'h600, 1'b0, 32'h0, 4'h0);

    // Reset with two outstanding; later responses must be dropped.
    next_cycle(); idle(); rst_i = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h9998; settle();
    check("t5_rst_rvalid", 128'({im_rvalid_o, dm_rvalid_o}), 128'h0);
    next_cycle(); idle(); rst_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h9999; settle();
    check("t5_drop1", 128'({im_rvalid_o, dm_rvalid_o}), 128'h0);
    next_cycle(); idle(); mem_rvalid_i = 1'b1; mem_rdata_i = 32'h999A; settle();
    check("t5_drop2", 128'({im_rvalid_o, dm_rvalid_o}), 128'h0);

    // F then D accepted, third blocked, responses routed in order.
    next_cycle(); idle(); im_valid_i = 1'b1; im_addr_i = 32'h700; mem_ready_i = 1'b1; exp_f(32'h700);
    next_cycle(); idle(); dm_valid_i = 1'b1; dm_addr_i = 32'h704; dm_we_i = 1'b1;
    dm_wdata_i = 32'h12345678; dm_wstrb_i = 4'hF; mem_ready_i = 1'b1;
    exp_d(32'h704, 1'b1, 32'h12345678, 4'hF);
    next_cycle(); idle(); im_valid_i = 1'b1; dm_valid_i = 1'b1; mem_ready_i = 1'b1; settle();
    check("t6_blocked", 128'({mem_valid_o, im_ready_o, dm_ready_o}), 128'h0);
    next_cycle(); idle(); im_valid_i = 1'b1; mem_ready_i = 1'b1; respond(1'b0, 32'hAAAA0001); settle();
    check("t6_no_same_cycle_free", 128'(im_ready_o), 128'h0);
    next_cycle(); idle(); respond(1'b1, 32'hBBBB0002); settle();
    check("t6_second_to_data", 128'(dm_rvalid_o), 128'h1);
    next_cycle(); idle();
    next_cycle();

    check("xfer_queue_empty", 128'(xq.size()), 128'h0);
    check("rsp_queue_empty", 128'(rq.size()), 128'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
